sr_latch: RTL and testbench
===========================

Name: sr_latch

Overview:
Clocked set/reset storage element: per-bit S sets, R clears, neither holds, sampled on the rising edge of C. Q and its complement nQ are registered, so Q and nQ are never equal. Used as a sticky flag / status bit cell, optionally replicated WIDTH times. Sits between control logic that produces set/clear pulses and consumers needing a stable level.

Parameters:
WIDTH, 1, number of independent SR cells (bit i of every vector port belongs to cell i)
COLLIDE_MODE, 0, action when S and R are both 1 for a cell: 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle
RESET_VALUE, 0, WIDTH-bit value loaded into Q by reset; nQ loads its complement

Ports:
C  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of C
S  input  WIDTH  set request per cell, active high, level sampled at each rising edge
R  input  WIDTH  reset request per cell, active high, level sampled at each rising edge
Q  output  WIDTH  registered cell state
nQ  output  WIDTH  registered complement of Q
collide  output  WIDTH  registered flag: 1 for one cycle when the cell saw S=R=1 on the previous edge

Behaviour:
- Single clock domain (C); one reset (rst_n), synchronous, active-low; no asynchronous paths.
- Reset: on rising edge of C with rst_n=0: Q<=RESET_VALUE, nQ<=~RESET_VALUE, collide<=0. Reset overrides S and R.
- Per cell i, on rising edge with rst_n=1:
  - S=0,R=0: Q holds.
  - S=1,R=0: Q<=1.
  - S=0,R=1: Q<=0.
  - S=1,R=1: per COLLIDE_MODE (0 hold, 1 Q<=1, 2 Q<=0, 3 Q<=~Q); collide<=1.
  - Otherwise collide<=0.
- nQ is a separate register loaded with the complement of Q's next value; invariant nQ==~Q at all times after the first clock edge, including out of reset.
- Latency: one cycle from S/R sampled to Q/nQ/collide update. No combinational path from S/R to any output.
- Inputs between edges are ignored; a pulse that does not straddle a rising edge has no effect.
- Cells are fully independent; no cross-bit interaction.
- Before the first reset edge, outputs are undefined; reset must be held low for at least one rising edge.
- Illegal COLLIDE_MODE values (>3) behave as 0 (hold).

Optional Feature:
Macro SR_LATCH_COLLIDE_STICKY_EN.
- Defined: collide becomes sticky per cell; set to 1 by any S=R=1 edge and cleared only by reset (rst_n=0). Q/nQ behaviour unchanged.
- Not defined: collide is a one-cycle pulse as described in Behaviour.

Test Plan:
- Reset: rst_n=0 for 2 edges, S=1,R=1 driven -> Q=0, nQ=1, collide=0 (RESET_VALUE=0).
- Set/hold: release reset, S=1 for one edge then S=0 -> Q=1, nQ=0 one cycle later, held at 1 over next 5 edges.
- Reset input: from Q=1, R=1 for one edge then R=0 -> Q=0, nQ=1, held; a repeated S pulse returns Q to 1.
- Collision per mode: Q=0 then S=R=1 for one edge -> mode0 Q=0, mode1 Q=1, mode2 Q=0, mode3 Q=1 (second collision edge toggles back to 0); collide=1 for exactly one cycle.
- Sub-cycle pulse: S=1 asserted and removed between two rising edges -> Q unchanged.
- WIDTH=4, sticky macro defined: S=4'b0101 then R=4'b0001 then S=R=4'b1000 -> Q=4'b0100 then 4'b0100 (cell3 held, mode0), collide=4'b1000 stays set until rst_n=0.

Source files
------------

// File: rtl/sr_latch.sv
// Clocked per-bit set/reset cell with registered Q, nQ and collision flag; optional SR_LATCH_COLLIDE_STICKY_EN.
// Latency: one C edge from S/R sample to Q/nQ/collide; no combinational input-to-output path.
// Backpressure: none; every edge samples S/R levels unconditionally.
module sr_latch #(
    parameter int                 WIDTH        = 1,
    parameter int                 COLLIDE_MODE = 0,
    parameter logic [WIDTH-1:0]   RESET_VALUE  = '0
) (
    input  logic             C,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic [WIDTH-1:0] collide
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] nq_q, nq_d;
    logic [WIDTH-1:0] collide_q, collide_d;
    logic [WIDTH-1:0] both;
    logic [WIDTH-1:0] coll_val;

    always_comb begin
        both     = S & R;
        coll_val = q_q;
        // Out-of-range modes fall back to hold.
        case (COLLIDE_MODE)
            1:       coll_val = '1;
            2:       coll_val = '0;
            3:       coll_val = ~q_q;
            default: coll_val = q_q;
        endcase
        q_d  = (q_q & ~S & ~R) | (S & ~R) | (both & coll_val);
        nq_d = ~q_d;
`ifdef SR_LATCH_COLLIDE_STICKY_EN
        collide_d = collide_q | both;
`else
        collide_d = both;
`endif
    end

    always_ff @(posedge C) begin
        if (!rst_n) begin
            q_q       <= RESET_VALUE;
            nq_q      <= ~RESET_VALUE;
            collide_q <= '0;
        end else begin
            q_q       <= q_d;
            nq_q      <= nq_d;
            collide_q <= collide_d;
        end
    end

    assign Q       = q_q;
    assign nQ      = nq_q;
    assign collide = collide_q;

endmodule

// File: tb/tb_sr_latch.sv
// Directed bench for sr_latch: reset, set/hold, clear, collision modes, sub-cycle pulse, WIDTH=4.
module tb_sr_latch;

    logic       C;
    logic       rst_n;
    logic       s1, r1;
    logic [3:0] s4, r4;
    logic       q0, nq0, c0, q1, nq1, c1, q2, nq2, c2, q3, nq3, c3;
    logic [3:0] q4, nq4, c4, q5, nq5, c5;
    int         checks = 0;
    int         errors = 0;

`ifdef SR_LATCH_COLLIDE_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    sr_latch #(.WIDTH(1), .COLLIDE_MODE(0)) u0 (.C(C), .rst_n(rst_n), .S(s1), .R(r1), .Q(q0), .nQ(nq0), .collide(c0));
    sr_latch #(.WIDTH(1), .COLLIDE_MODE(1)) u1 (.C(C), .rst_n(rst_n), .S(s1), .R(r1), .Q(q1), .nQ(nq1), .collide(c1));
    sr_latch #(.WIDTH(1), .COLLIDE_MODE(2)) u2 (.C(C), .rst_n(rst_n), .S(s1), .R(r1), .Q(q2), .nQ(nq2), .collide(c2));
    sr_latch #(.WIDTH(1), .COLLIDE_MODE(3)) u3 (.C(C), .rst_n(rst_n), .S(s1), .R(r1), .Q(q3), .nQ(nq3), .collide(c3));
    sr_latch #(.WIDTH(4), .COLLIDE_MODE(0)) u4 (.C(C), .rst_n(rst_n), .S(s4), .R(r4), .Q(q4), .nQ(nq4), .collide(c4));
    sr_latch #(.WIDTH(4), .COLLIDE_MODE(0), .RESET_VALUE(4'b1010)) u5
        (.C(C), .rst_n(rst_n), .S(s4), .R(r4), .Q(q5), .nQ(nq5), .collide(c5));

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; s1 = 1'b1; r1 = 1'b1; s4 = 4'hF; r4 = 4'hF;
        step(); step();
        check("rst_q0", q0, 0);   check("rst_nq0", nq0, 1);  check("rst_c0", c0, 0);
        check("rst_q3", q3, 0);   check("rst_c3", c3, 0);
        check("rst_q4", q4, 4'b0000); check("rst_c4", c4, 4'b0000);
        check("rst_q5", q5, 4'b1010); check("rst_nq5", nq5, 4'b0101);

        rst_n = 1'b1; s1 = 1'b0; r1 = 1'b0; s4 = 4'b0000; r4 = 4'b0000;
        step();
        check("idle_q0", q0, 0); check("idle_q5", q5, 4'b1010);

        s1 = 1'b1; step(); s1 = 1'b0;
        check("set_q0", q0, 1); check("set_nq0", nq0, 0); check("set_q2", q2, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_q0", q0, 1); check("hold_nq0", nq0, 0);
        end

        r1 = 1'b1; step(); r1 = 1'b0;
        check("clr_q0", q0, 0); check("clr_nq0", nq0, 1); check("clr_q1", q1, 0);
        step();
        check("clrhold_q0", q0, 0);
        s1 = 1'b1; step(); s1 = 1'b0;
        check("reset_q0", q0, 1);
        r1 = 1'b1; step(); r1 = 1'b0;
        check("reclr_q3", q3, 0);

        s1 = 1'b1; r1 = 1'b1; step(); s1 = 1'b0; r1 = 1'b0;
        check("col_m0_q", q0, 0); check("col_m1_q", q1, 1); check("col_m1_nq", nq1, 0);
        check("col_m2_q", q2, 0); check("col_m3_q", q3, 1); check("col_m3_nq", nq3, 0);
        check("col_c0", c0, 1); check("col_c1", c1, 1); check("col_c2", c2, 1); check("col_c3", c3, 1);
        step();
        check("colnext_c0", c0, {3'b0, STICKY}); check("colnext_c3", c3, {3'b0, STICKY});
        check("colnext_q3", q3, 1); check("colnext_q1", q1, 1);
        s1 = 1'b1; r1 = 1'b1; step(); s1 = 1'b0; r1 = 1'b0;
        check("tog_m3_q", q3, 0); check("tog_m3_nq", nq3, 1); check("tog_m1_q", q1, 1);
        check("tog_m2_q", q2, 0); check("tog_c3", c3, 1);
        step();
        check("tognext_c3", c3, {3'b0, STICKY});

        @(posedge C); #1; s1 = 1'b1; #3; s1 = 1'b0;
        step();
        check("glitch_q0", q0, 0); check("glitch_q2", q2, 0); check("glitch_q3", q3, 0);

        s4 = 4'b0101; step(); s4 = 4'b0000;
        check("w4_set_q4", q4, 4'b0101); check("w4_set_nq4", nq4, 4'b1010); check("w4_set_q5", q5, 4'b1111);
        r4 = 4'b0001; step(); r4 = 4'b0000;
        check("w4_clr_q4", q4, 4'b0100); check("w4_clr_q5", q5, 4'b1110);
        s4 = 4'b1000; r4 = 4'b1000; step(); s4 = 4'b0000; r4 = 4'b0000;
        check("w4_col_q4", q4, 4'b0100); check("w4_col_c4", c4, 4'b1000);
        check("w4_col_q5", q5, 4'b1110); check("w4_col_nq5", nq5, 4'b0001);
        step();
        check("w4_after_c4", c4, {STICKY, 3'b000}); check("w4_after_q4", q4, 4'b0100);
        step();
        check("w4_after2_c4", c4, {STICKY, 3'b000});

        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("final_rst_c4", c4, 4'b0000); check("final_rst_q4", q4, 4'b0000);
        check("final_rst_q5", q5, 4'b1010); check("final_rst_c0", c0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
